// File: rtl/booth_mul_sched_pkg.sv
// booth_mul_sched_pkg
// Shared definitions for the two-requester Booth multiplier scheduler:
//   - state_t     : scheduler FSM states (IDLE, RUN, DONE)
//   - BW_DEFAULT  : default operand width
//   - cnt_width() : width of the Booth step counter for a given operand width
package booth_mul_sched_pkg;

    localparam int BW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter only has to reach BW-1; clog2(BW+1) also leaves room for BW itself.
    function automatic int cnt_width(input int bw);
        return $clog2(bw + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step
// One combinational radix-2 Booth iteration on the product register
// {acc, q, q_1}, followed by the arithmetic right shift.
// Ports:
//   acc_i [BW:0]   accumulator (one guard bit so m = -2^(BW-1) cannot overflow)
//   q_i   [BW-1:0] multiplier / low half of the product
//   q1_i           Booth history bit
//   m_i   [BW-1:0] signed multiplicand
//   acc_o, q_o, q1_o  product register after the step and the shift
module booth_step
    import booth_mul_sched_pkg::*;
#(
    parameter int BW = BW_DEFAULT
) (
    input  logic [BW:0]   acc_i,
    input  logic [BW-1:0] q_i,
    input  logic          q1_i,
    input  logic [BW-1:0] m_i,
    output logic [BW:0]   acc_o,
    output logic [BW-1:0] q_o,
    output logic          q1_o
);

    logic [BW:0] m_ext;
    logic [BW:0] sum;

    always_comb begin
        m_ext = {m_i[BW-1], m_i};
        case ({q_i[0], q1_i})
            2'b01:   sum = acc_i + m_ext;
            2'b10:   sum = acc_i - m_ext;
            default: sum = acc_i;
        endcase
        // Arithmetic right shift of the whole {sum, q, q_1} chain by one bit.
        acc_o = {sum[BW], sum[BW:1]};
        q_o   = {sum[0], q_i[BW-1:1]};
        q1_o  = q_i[0];
    end

endmodule

// File: rtl/booth_mul_sched.sv
// booth_mul_sched
// Two requesters share one iterative radix-2 Booth multiplier. A round-robin
// arbiter picks a requester in IDLE, the datapath runs BW steps in RUN, and the
// signed 2*BW-bit product is held in DONE until the consumer takes it.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/m/q/ready     requester N handshake and signed operands (N = 0, 1)
//   res_valid/data/id/ready  result handshake, product and owning requester
//   busy                     high whenever the scheduler is not IDLE
module booth_mul_sched
    import booth_mul_sched_pkg::*;
#(
    parameter int BW = BW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [BW-1:0]   req0_m,
    input  logic [BW-1:0]   req0_q,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [BW-1:0]   req1_m,
    input  logic [BW-1:0]   req1_q,
    output logic            req1_ready,
    output logic            res_valid,
    output logic [2*BW-1:0] res_data,
    output logic            res_id,
    input  logic            res_ready,
    output logic            busy
);

    localparam int            CW        = cnt_width(BW);
    localparam logic [CW-1:0] LAST_STEP = CW'(BW - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rr_q, rr_d;              // requester favoured when both are valid
    logic [BW:0]       acc_q, acc_d;
    logic [BW-1:0]     mq_q, mq_d;              // multiplier, becomes the product low half
    logic              q1_q, q1_d;
    logic [BW-1:0]     mcand_q, mcand_d;
    logic              owner_q, owner_d;        // requester whose operation is in flight
    logic              res_valid_q, res_valid_d;
    logic [2*BW-1:0]   res_data_q, res_data_d;
    logic              res_id_q, res_id_d;

    logic              any_valid;
    logic              grant;
    logic [BW:0]       step_acc;
    logic [BW-1:0]     step_q;
    logic              step_q1;

    booth_step #(
        .BW(BW)
    ) u_booth_step (
        .acc_i (acc_q),
        .q_i   (mq_q),
        .q1_i  (q1_q),
        .m_i   (mcand_q),
        .acc_o (step_acc),
        .q_o   (step_q),
        .q1_o  (step_q1)
    );

    // Arbiter: a lone requester always wins; a tie goes to the pointer.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = rr_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && any_valid && !grant;
    assign req1_ready = (state_q == IDLE) && any_valid &&  grant;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        q1_d        = q1_q;
        mcand_d     = mcand_q;
        owner_d     = owner_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    owner_d = grant;
                    mcand_d = grant ? req1_m : req0_m;
                    mq_d    = grant ? req1_q : req0_q;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    rr_d    = ~grant;       // the other requester wins the next tie
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step_acc;
                mq_d  = step_q;
                q1_d  = step_q1;
                if (cnt_q == LAST_STEP) begin
                    // The guard bit of acc is dropped: the product always fits in 2*BW bits.
                    res_data_d  = {step_acc[BW-1:0], step_q};
                    res_id_d    = owner_q;
                    res_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            acc_q       <= '0;
            mq_q        <= '0;
            q1_q        <= 1'b0;
            mcand_q     <= '0;
            owner_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            acc_q       <= acc_d;
            mq_q        <= mq_d;
            q1_q        <= q1_d;
            mcand_q     <= mcand_d;
            owner_q     <= owner_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule
